// File: rtl/gtx_reset_seq_pkg.sv
// rtl/gtx_reset_seq_pkg.sv - state encodings and helpers shared by the GTX reset sequencer
package gtx_reset_seq_pkg;

    // Encodings are also decoded by the status register block; keep them stable.
    typedef enum logic [2:0] {
        ST_POWERUP  = 3'd0,
        ST_PLL_RST  = 3'd1,
        ST_PLL_WAIT = 3'd2,
        ST_GT_RST   = 3'd3,
        ST_GT_WAIT  = 3'd4,
        ST_RUN      = 3'd5
    } state_e;

    localparam int N_SYNC = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gtx_reset_seq_if.sv
// rtl/gtx_reset_seq_if.sv - control/status bundle between the reset sequencer and the GTX wrapper
interface gtx_reset_seq_if;
    logic       cpll_locked;
    logic       tx_resetdone;
    logic       rx_resetdone;
    logic       tx_fsm_resetdone;
    logic       rx_fsm_resetdone;
    logic [1:0] usr_clk_rdy;
    logic       cpll_reset;
    logic       gt_reset;

    modport master (
        input  cpll_locked, tx_resetdone, rx_resetdone,
        input  tx_fsm_resetdone, rx_fsm_resetdone, usr_clk_rdy,
        output cpll_reset, gt_reset
    );

    modport slave (
        output cpll_locked, tx_resetdone, rx_resetdone,
        output tx_fsm_resetdone, rx_fsm_resetdone, usr_clk_rdy,
        input  cpll_reset, gt_reset
    );
endinterface

// File: rtl/gtx_reset_seq_status_sync2.sv
// rtl/gtx_reset_seq_status_sync2.sv - parameterised-width two-flop synchroniser
module status_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta_q;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/gtx_reset_seq.sv
// rtl/gtx_reset_seq.sv - CPLL/GT reset sequencer with lock/resetdone monitoring and timed retries
module gtx_reset_seq
    import gtx_reset_seq_pkg::*;
#(
    parameter int pwrup_cyc    = 60,
    parameter int cpll_rst_cyc = 60,
    parameter int gt_rst_cyc   = 16,
    parameter int tmo_dw       = 16,
    parameter int retry_dw     = 8
) (
    input  logic                drp_clk,
    input  logic                reset_n,
    input  logic                soft_reset,
    gtx_reset_seq_if.master     gt,
    output logic                ready,
    output logic [2:0]          state_mon,
    output logic [retry_dw-1:0] retries,
    output logic                timeout_seen
);
    localparam int CNT_W = max_int(tmo_dw, max_int($clog2(pwrup_cyc),
                                   max_int($clog2(cpll_rst_cyc), $clog2(gt_rst_cyc))));

    localparam logic [CNT_W-1:0]    PWRUP_LAST = CNT_W'(pwrup_cyc - 1);
    localparam logic [CNT_W-1:0]    CPLL_LAST  = CNT_W'(cpll_rst_cyc - 1);
    localparam logic [CNT_W-1:0]    GT_LAST    = CNT_W'(gt_rst_cyc - 1);
    localparam logic [CNT_W-1:0]    TMO_LAST   = CNT_W'((64'd1 << tmo_dw) - 64'd1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [retry_dw-1:0] RETRY_ONE  = retry_dw'(1);

    logic [N_SYNC-1:0] async_in;
    logic [N_SYNC-1:0] sync_in;
    logic              soft_s;
    logic              locked_s;
    logic              all_done;

    assign async_in = {soft_reset, gt.usr_clk_rdy, gt.rx_fsm_resetdone, gt.tx_fsm_resetdone,
                       gt.rx_resetdone, gt.tx_resetdone, gt.cpll_locked};

    status_sync2 #(.WIDTH(N_SYNC)) u_sync (
        .clk   (drp_clk),
        .rst_n (reset_n),
        .d     (async_in),
        .q     (sync_in)
    );

    assign soft_s   = sync_in[7];
    assign locked_s = sync_in[0];
    assign all_done = &sync_in[6:1];

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [retry_dw-1:0] retries_q, retries_d;
    logic                timeout_seen_q, timeout_seen_d;
    logic                cpll_reset_q, cpll_reset_d;
    logic                gt_reset_q, gt_reset_d;
    logic                ready_q, ready_d;
    logic                enter;
    logic                retry_inc;
    logic                tmo_hit;

    always_ff @(posedge drp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_POWERUP;
            cnt_q          <= '0;
            retries_q      <= '0;
            timeout_seen_q <= 1'b0;
            cpll_reset_q   <= 1'b0;
            gt_reset_q     <= 1'b1;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retries_q      <= retries_d;
            timeout_seen_q <= timeout_seen_d;
            cpll_reset_q   <= cpll_reset_d;
            gt_reset_q     <= gt_reset_d;
            ready_q        <= ready_d;
        end
    end

    // Branch order inside each wait state encodes lock loss > timeout > progress.
    always_comb begin
        state_d   = state_q;
        enter     = 1'b0;
        retry_inc = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = ST_PLL_RST;
                    enter   = 1'b1;
                end
            end
            ST_PLL_RST: begin
                if (cnt_q == CPLL_LAST) begin
                    state_d = ST_PLL_WAIT;
                    enter   = 1'b1;
                end
            end
            ST_PLL_WAIT: begin
                if (cnt_q == TMO_LAST) begin
                    state_d   = ST_PLL_RST;
                    enter     = 1'b1;
                    retry_inc = 1'b1;
                    tmo_hit   = 1'b1;
                end else if (locked_s) begin
                    state_d = ST_GT_RST;
                    enter   = 1'b1;
                end
            end
            ST_GT_RST: begin
                if (cnt_q == GT_LAST) begin
                    state_d = ST_GT_WAIT;
                    enter   = 1'b1;
                end
            end
            ST_GT_WAIT: begin
                if (!locked_s) begin
                    state_d   = ST_PLL_RST;
                    enter     = 1'b1;
                    retry_inc = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ST_PLL_RST;
                    enter     = 1'b1;
                    retry_inc = 1'b1;
                    tmo_hit   = 1'b1;
                end else if (all_done) begin
                    state_d = ST_RUN;
                    enter   = 1'b1;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d   = ST_PLL_RST;
                    enter     = 1'b1;
                    retry_inc = 1'b1;
                end else if (!all_done) begin
                    state_d   = ST_GT_RST;
                    enter     = 1'b1;
                    retry_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_POWERUP;
                enter   = 1'b1;
            end
        endcase

        // A held soft reset re-enters PLL_RST every cycle, pinning the counter at zero.
        if (soft_s && (state_q != ST_POWERUP) && (state_q <= ST_RUN)) begin
            state_d   = ST_PLL_RST;
            enter     = 1'b1;
            retry_inc = 1'b0;
            tmo_hit   = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (enter) begin
            cnt_d = '0;
        end else if (state_q != ST_RUN) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        retries_d = retries_q;
        if (retry_inc && (retries_q != '1)) begin
            retries_d = retries_q + RETRY_ONE;
        end
        timeout_seen_d = timeout_seen_q | tmo_hit;

        cpll_reset_d = (state_d == ST_PLL_RST);
        gt_reset_d   = !((state_d == ST_GT_WAIT) || (state_d == ST_RUN));
        ready_d      = (state_d == ST_RUN);
    end

    assign gt.cpll_reset = cpll_reset_q;
    assign gt.gt_reset   = gt_reset_q;
    assign ready         = ready_q;
    assign state_mon     = state_q;
    assign retries       = retries_q;
    assign timeout_seen  = timeout_seen_q;
endmodule

// File: tb/tb_gtx_reset_seq.sv
// tb/tb_gtx_reset_seq.sv - directed self-checking bench for gtx_reset_seq
module tb_gtx_reset_seq;
    logic       clk;
    logic       reset_n, reset_n_b;
    logic       soft_reset, soft_reset_b;
    logic       ready_a, ready_b;
    logic [2:0] state_a, state_b;
    logic [7:0] retries_a;
    logic [1:0] retries_b;
    logic       tmo_a, tmo_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit mon_en  = 0;

    typedef struct {
        int         at;
        logic [2:0] outs;
    } ev_t;
    ev_t exp_q[$];
    logic [2:0] prev_outs = 3'b000;

    gtx_reset_seq_if gif_a ();
    gtx_reset_seq_if gif_b ();

    gtx_reset_seq u_dut_a (
        .drp_clk      (clk),
        .reset_n      (reset_n),
        .soft_reset   (soft_reset),
        .gt           (gif_a),
        .ready        (ready_a),
        .state_mon    (state_a),
        .retries      (retries_a),
        .timeout_seen (tmo_a)
    );

    gtx_reset_seq #(.tmo_dw(6), .retry_dw(2)) u_dut_b (
        .drp_clk      (clk),
        .reset_n      (reset_n_b),
        .soft_reset   (soft_reset_b),
        .gt           (gif_b),
        .ready        (ready_b),
        .state_mon    (state_b),
        .retries      (retries_b),
        .timeout_seen (tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every change of {cpll_reset, gt_reset, ready} on DUT A must match the next expected event.
    always @(negedge clk) begin
        logic [2:0] cur;
        ev_t        e;
        cur = {gif_a.cpll_reset, gif_a.gt_reset, ready_a};
        if (mon_en && (cur !== prev_outs)) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL out_event: unexpected outs=%b at cyc %0d", cur, cyc);
            end else begin
                e = exp_q.pop_front();
                assert ((cur === e.outs) && (cyc == e.at)) else begin
                    n_fail++;
                    $error("FAIL out_event: got outs=%b at cyc %0d, expected outs=%b at cyc %0d",
                           cur, cyc, e.outs, e.at);
                end
            end
        end
        prev_outs = cur;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_ev(input int at, input logic [2:0] outs);
        ev_t e;
        e.at   = at;
        e.outs = outs;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_cpll"},  32'(gif_a.cpll_reset), 32'd0);
        check({tag, "_gt"},    32'(gif_a.gt_reset),   32'd1);
        check({tag, "_ready"}, 32'(ready_a),          32'd0);
        check({tag, "_state"}, 32'(state_a),          32'd0);
        check({tag, "_retry"}, 32'(retries_a),        32'd0);
        check({tag, "_tmo"},   32'(tmo_a),            32'd0);
    endtask

    initial begin
        int r, l, d, s, e;
        reset_n      = 1'b1;
        reset_n_b    = 1'b1;
        soft_reset   = 1'b0;
        soft_reset_b = 1'b0;
        gif_a.cpll_locked = 1'b0; gif_a.tx_resetdone = 1'b0; gif_a.rx_resetdone = 1'b0;
        gif_a.tx_fsm_resetdone = 1'b0; gif_a.rx_fsm_resetdone = 1'b0; gif_a.usr_clk_rdy = 2'b00;
        gif_b.cpll_locked = 1'b0; gif_b.tx_resetdone = 1'b0; gif_b.rx_resetdone = 1'b0;
        gif_b.tx_fsm_resetdone = 1'b0; gif_b.rx_fsm_resetdone = 1'b0; gif_b.usr_clk_rdy = 2'b00;
        #1;
        reset_n   = 1'b0;
        reset_n_b = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        mon_en = 1;

        // PLL timeout loop on DUT B: lock never arrives, retries saturate at 3
        r = cyc;
        reset_n_b = 1'b1;
        wait_to(r + 183);
        check("b_pll_wait_state", 32'(state_b),   32'd2);
        check("b_pre_tmo_retry",  32'(retries_b), 32'd0);
        check("b_pre_tmo_flag",   32'(tmo_b),     32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_to(r + 184 + 124 * k);
            check("b_tmo_state", 32'(state_b),   32'd1);
            check("b_tmo_retry", 32'(retries_b), (k < 2) ? 32'(k + 1) : 32'd3);
            check("b_tmo_flag",  32'(tmo_b),     32'd1);
        end
        check_reset_a("held");

        // Nominal bring-up on DUT A
        r = cyc;
        reset_n = 1'b1;
        push_ev(r + 60,  3'b110);
        push_ev(r + 120, 3'b010);
        wait_to(r + 59);
        check("pwrup_state", 32'(state_a), 32'd0);
        wait_to(r + 220);
        gif_a.cpll_locked = 1'b1;
        push_ev(r + 239, 3'b000);
        wait_to(r + 230);
        check("gt_rst_state", 32'(state_a), 32'd3);
        wait_to(r + 289);
        gif_a.tx_resetdone = 1'b1; gif_a.rx_resetdone = 1'b1;
        gif_a.tx_fsm_resetdone = 1'b1; gif_a.rx_fsm_resetdone = 1'b1; gif_a.usr_clk_rdy = 2'b11;
        push_ev(r + 292, 3'b001);
        wait_to(r + 295);
        check("nom_state", 32'(state_a),   32'd5);
        check("nom_retry", 32'(retries_a), 32'd0);
        check("nom_tmo",   32'(tmo_a),     32'd0);

        // One-cycle lock loss in RUN
        l = cyc;
        gif_a.cpll_locked = 1'b0;
        push_ev(l + 3,  3'b110);
        push_ev(l + 63, 3'b010);
        push_ev(l + 80, 3'b000);
        push_ev(l + 81, 3'b001);
        @(negedge clk);
        gif_a.cpll_locked = 1'b1;
        wait_to(l + 3);
        check("lock_loss_state", 32'(state_a), 32'd1);
        wait_to(l + 85);
        check("lock_loss_retry", 32'(retries_a), 32'd1);
        check("lock_loss_run",   32'(state_a),   32'd5);

        // rx_resetdone drop in RUN goes to GT_RST only
        d = cyc;
        gif_a.rx_resetdone = 1'b0;
        push_ev(d + 3,  3'b010);
        push_ev(d + 19, 3'b000);
        push_ev(d + 20, 3'b001);
        @(negedge clk);
        gif_a.rx_resetdone = 1'b1;
        wait_to(d + 3);
        check("rxdone_state", 32'(state_a), 32'd3);
        wait_to(d + 24);
        check("rxdone_retry", 32'(retries_a), 32'd2);

        // soft_reset held 200 cycles while parked in GT_WAIT
        d = cyc;
        gif_a.rx_resetdone = 1'b0;
        push_ev(d + 3,  3'b010);
        push_ev(d + 19, 3'b000);
        wait_to(d + 29);
        check("park_state", 32'(state_a), 32'd4);
        s = cyc;
        soft_reset = 1'b1;
        push_ev(s + 3, 3'b110);
        wait_to(s + 100);
        check("soft_hold_state", 32'(state_a),   32'd1);
        check("soft_hold_retry", 32'(retries_a), 32'd3);
        wait_to(s + 200);
        soft_reset = 1'b0;
        push_ev(s + 262, 3'b010);
        push_ev(s + 279, 3'b000);
        wait_to(s + 290);
        gif_a.rx_resetdone = 1'b1;
        push_ev(s + 293, 3'b001);
        wait_to(s + 296);
        check("soft_run_state", 32'(state_a),   32'd5);
        check("soft_run_retry", 32'(retries_a), 32'd3);

        // Asynchronous reset in the middle of GT_RST
        d = cyc;
        gif_a.rx_resetdone = 1'b0;
        push_ev(d + 3, 3'b010);
        @(negedge clk);
        gif_a.rx_resetdone = 1'b1;
        wait_to(d + 10);
        check("pre_async_state", 32'(state_a), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_a("async");
        wait_to(d + 13);
        e = cyc;
        reset_n = 1'b1;
        push_ev(e + 60,  3'b110);
        push_ev(e + 120, 3'b010);
        push_ev(e + 137, 3'b000);
        push_ev(e + 138, 3'b001);
        wait_to(e + 59);
        check("rerun_pwrup_state", 32'(state_a), 32'd0);
        wait_to(e + 145);
        check("rerun_state", 32'(state_a),   32'd5);
        check("rerun_retry", 32'(retries_a), 32'd0);
        check("events_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
